spi_byte_engine: RTL and testbench
==================================

SPI_BYTE_ENGINE -- requirements
Module: spi_byte_engine

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning the width of the clk_div input.
REQ-002 SHALL have port p_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port p_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port clk_div, input, DIV_W bits: half-period H = clk_div+1 p_clk cycles.
REQ-005 SHALL have port tx_data, input, 8 bits: the byte to transmit.
REQ-006 SHALL have ports tx_valid (input, 1 bit) and tx_ready (output, 1 bit) forming the byte handshake.
REQ-007 SHALL have port tx_last, input, 1 bit: release chip select after this byte.
REQ-008 SHALL have ports rx_data (output, 8 bits) and rx_valid (output, 1 bit): the received byte and its one-cycle strobe.
REQ-009 SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-010 SHALL have ports s_clk (output, 1 bit), s_css (output, 1 bit, chip select, active-low), s_mosi (output, 1 bit) and s_miso (input, 1 bit).

Function
REQ-011 SHALL implement SPI mode 0, MSB first: s_clk idles low, s_mosi changes on falling edges, s_miso is sampled on rising edges.
REQ-012 SHALL use the states IDLE, SHIFT, WAIT, HOLD and GAP, with all outputs driven from registers.
REQ-013 SHALL accept a byte when tx_valid and tx_ready are high in the same cycle; tx_data, tx_last and clk_div are captured only at acceptance.
REQ-014 SHALL assert tx_ready only in IDLE and WAIT.
REQ-015 SHALL, on acceptance in IDLE at cycle 0, drive s_css=0 and s_mosi=bit7 at cycle 1, then toggle s_clk every H cycles; the first rising edge occurs at cycle 1+H.
REQ-016 SHALL emit 8 rising and 8 falling s_clk edges per byte, presenting the next bit on each of the first 7 falling edges.
REQ-017 SHALL assert rx_valid for exactly one cycle, in the cycle s_clk goes low after the 8th rising edge, with rx_data holding the 8 sampled bits.
REQ-018 SHALL hold rx_data stable until the next rx_valid.
REQ-019 SHALL, after a byte with tx_last=0, enter WAIT: s_css low, s_clk low, tx_ready high.
REQ-020 SHALL, on acceptance in WAIT, load the new byte and present bit7 on s_mosi in the next cycle, with no chip-select deassertion between bytes.
REQ-021 SHALL remain in WAIT indefinitely while tx_valid is low.
REQ-022 SHALL, after a byte with tx_last=1, enter HOLD for H cycles (s_css low), then drive s_css=1 and enter GAP for H cycles, then return to IDLE.
REQ-023 SHALL, with clk_div=0 (H=1), produce s_clk = p_clk/2.
REQ-024 SHALL, with clk_div at its maximum value, count H = 2^DIV_W without counter wrap error.
REQ-025 SHALL ignore changes on clk_div during a byte.
REQ-026 SHALL ignore tx_valid asserted during SHIFT, HOLD or GAP; that byte is not accepted.

Reset
REQ-027 SHALL, while p_reset_n=0, force state=IDLE, s_css=1, s_clk=0, s_mosi=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0 and clear the counters.
REQ-028 SHALL raise tx_ready in the first p_clk cycle after p_reset_n deasserts.
REQ-029 SHALL, on reset asserted mid-byte, immediately drive s_css=1 and s_clk=0, produce no rx_valid, and discard the partial byte.

Configuration
REQ-030 SHALL, when macro SPI_LSB_FIRST_EN is defined, add input port lsb_first (1 bit), sampled at acceptance; when it is high, the byte is shifted and assembled LSB first.
REQ-031 SHALL, when SPI_LSB_FIRST_EN is undefined, have no lsb_first port and operate MSB first only.

Structure
REQ-032 SHALL take the state enumeration, SPI_BITS=8 and the reset values of the state and counters from a shared package spi_pkg.
REQ-033 SHALL contain one sub-module spi_clk_tick: a loadable half-period counter producing a one-cycle tick every H cycles while enabled.

Verification
REQ-034 SHALL verify: clk_div=0, tx_data=0xA5, tx_last=1, s_miso looped back from s_mosi -> s_mosi sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; rx_valid at cycle 17; s_css high at cycle 18+1.
REQ-035 SHALL verify: clk_div=3, bytes 0x9F (tx_last=0) then 0x00 (tx_last=1), slave returns 0xFF then 0xEF -> s_css low continuously across both bytes; 16 rising edges 8 cycles apart; rx 0xFF then 0xEF.
REQ-036 SHALL verify: byte 0x03 with tx_last=0, then tx_valid low for 50 cycles -> WAIT held with s_css=0, s_clk=0, tx_ready=1, no extra edges.
REQ-037 SHALL verify: p_reset_n pulsed low after the 4th rising edge -> s_css=1, s_clk=0 asynchronously; no rx_valid; tx_ready=1 one cycle after release.
REQ-038 SHALL verify: clk_div changed from 1 to 7 mid-byte and tx_valid held high during SHIFT -> period unchanged for the current byte; no second acceptance until WAIT or IDLE.
REQ-039 SHALL verify: with SPI_LSB_FIRST_EN defined, lsb_first=1 and tx_data=0x01 -> the first s_mosi bit is 1; rx_data assembled LSB first.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding, bit counts and reset values for the SPI byte engine.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      WAIT,
      HOLD,
      GAP
   } state_t;

   localparam int SPI_BITS = 8;
   localparam int EDGE_W   = $clog2(2 * SPI_BITS + 1);

   localparam state_t STATE_RST = IDLE;
   localparam int     CNT_RST   = 0;

   localparam logic [EDGE_W-1:0] EDGE_RST = '0;
   localparam logic [EDGE_W-1:0] EDGE_RX  = EDGE_W'(2 * SPI_BITS - 1);
   localparam logic [EDGE_W-1:0] EDGE_END = EDGE_W'(2 * SPI_BITS);

   function automatic logic [SPI_BITS-1:0] bit_rev(
      input logic [SPI_BITS-1:0] d
   );
      logic [SPI_BITS-1:0] r;
      r = '0;
      for (int i = 0; i < SPI_BITS; i++) begin
         r[i] = d[SPI_BITS-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Loadable half-period counter: one-cycle tick every clk_div+1 cycles while
// enabled; the period is latched on load so later divider changes are ignored.
module spi_clk_tick
   import spi_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   input  logic             en,
   output logic             tick
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] per;

   assign tick = en && (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= DIV_W'(CNT_RST);
         per <= DIV_W'(CNT_RST);
      end else if (load) begin
         cnt <= load_val;
         per <= load_val;
      end else if (tick) begin
         cnt <= per;
      end else if (en) begin
         cnt <= cnt - DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte engine with chip-select hold/gap timing.
// Optional LSB-first shifting is enabled by defining SPI_LSB_FIRST_EN.
module spi_byte_engine
   import spi_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic                p_clk,
   input  logic                p_reset_n,
   input  logic [DIV_W-1:0]    clk_div,
   input  logic [SPI_BITS-1:0] tx_data,
   input  logic                tx_valid,
   output logic                tx_ready,
   input  logic                tx_last,
`ifdef SPI_LSB_FIRST_EN
   input  logic                lsb_first,
`endif
   output logic [SPI_BITS-1:0] rx_data,
   output logic                rx_valid,
   output logic                busy,
   output logic                s_clk,
   output logic                s_css,
   output logic                s_mosi,
   input  logic                s_miso
);

   state_t              state;
   logic [EDGE_W-1:0]   edge_cnt;
   logic [SPI_BITS-1:0] tx_sh;
   logic [SPI_BITS-1:0] rx_sh;
   logic [SPI_BITS-1:0] tx_ord;
   logic                last_q;
   logic                lsb_q;
   logic                lsb_in;
   logic                accept;
   logic                tick;
   logic                tick_en;

`ifdef SPI_LSB_FIRST_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   // Bytes are always shifted out MSB-side; LSB-first just pre-reverses.
   assign tx_ord  = lsb_in ? bit_rev(tx_data) : tx_data;
   assign accept  = tx_valid && tx_ready;
   assign tick_en = (state == SHIFT) || (state == HOLD) || (state == GAP);

   spi_clk_tick #(
      .DIV_W(DIV_W)
   ) u_tick (
      .clk     (p_clk),
      .rst_n   (p_reset_n),
      .load    (accept),
      .load_val(clk_div),
      .en      (tick_en),
      .tick    (tick)
   );

   always_ff @(posedge p_clk or negedge p_reset_n) begin
      if (!p_reset_n) begin
         state    <= STATE_RST;
         edge_cnt <= EDGE_RST;
         tx_sh    <= '0;
         rx_sh    <= '0;
         last_q   <= 1'b0;
         lsb_q    <= 1'b0;
         tx_ready <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         s_clk    <= 1'b0;
         s_css    <= 1'b1;
         s_mosi   <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         unique case (state)
            IDLE, WAIT: begin
               tx_ready <= 1'b1;
               if (accept) begin
                  state    <= SHIFT;
                  tx_ready <= 1'b0;
                  busy     <= 1'b1;
                  s_css    <= 1'b0;
                  s_clk    <= 1'b0;
                  tx_sh    <= tx_ord;
                  s_mosi   <= tx_ord[SPI_BITS-1];
                  edge_cnt <= EDGE_RST;
                  last_q   <= tx_last;
                  lsb_q    <= lsb_in;
               end
            end
            SHIFT: begin
               if (tick) begin
                  // The tick after the 16th edge closes the last low phase.
                  if (edge_cnt == EDGE_END) begin
                     if (last_q) begin
                        state <= HOLD;
                     end else begin
                        state    <= WAIT;
                        tx_ready <= 1'b1;
                     end
                  end else begin
                     edge_cnt <= edge_cnt + EDGE_W'(1);
                     s_clk    <= ~s_clk;
                     if (!s_clk) begin
                        rx_sh <= {rx_sh[SPI_BITS-2:0], s_miso};
                     end else if (edge_cnt == EDGE_RX) begin
                        rx_valid <= 1'b1;
                        rx_data  <= lsb_q ? bit_rev(rx_sh) : rx_sh;
                     end else begin
                        tx_sh  <= tx_sh << 1;
                        s_mosi <= tx_sh[SPI_BITS-2];
                     end
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  state <= GAP;
                  s_css <= 1'b1;
               end
            end
            GAP: begin
               if (tick) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: vector table plus multi-byte,
// wait, reset, divider-change and optional LSB-first sequences.
module tb_spi_byte_engine;

   localparam int DIV_W = 8;

   logic             p_clk = 1'b0;
   logic             p_reset_n = 1'b0;
   logic [DIV_W-1:0] clk_div = '0;
   logic [7:0]       tx_data = '0;
   logic             tx_valid = 1'b0;
   logic             tx_ready;
   logic             tx_last = 1'b0;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             busy;
   logic             s_clk;
   logic             s_css;
   logic             s_mosi;
   logic             s_miso;
`ifdef SPI_LSB_FIRST_EN
   logic             lsb_first = 1'b0;
`endif

   always #5 p_clk = ~p_clk;

   spi_byte_engine #(
      .DIV_W(DIV_W)
   ) dut (
      .p_clk    (p_clk),
      .p_reset_n(p_reset_n),
      .clk_div  (clk_div),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
`ifdef SPI_LSB_FIRST_EN
      .lsb_first(lsb_first),
`endif
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .busy     (busy),
      .s_clk    (s_clk),
      .s_css    (s_css),
      .s_mosi   (s_mosi),
      .s_miso   (s_miso)
   );

   int n_vec = 0;
   int n_bad = 0;

   // bus monitor and slave model
   int          cyc = 0;
   logic        prev_clk = 1'b0;
   logic        prev_css = 1'b1;
   logic        prev_busy = 1'b0;
   int          rise_t[$];
   logic        mosi_q[$];
   int          rx_t[$];
   logic [7:0]  rx_q[$];
   int          css_t[$];
   int          acc_t[$];
   int          idle_t = -1;
   logic [15:0] sl_sh = '0;
   logic        loop_en = 1'b1;

   assign s_miso = loop_en ? s_mosi : sl_sh[15];

   always @(negedge p_clk) begin
      cyc = cyc + 1;
      if (tx_valid && tx_ready) acc_t.push_back(cyc);
      if (s_clk && !prev_clk) begin
         rise_t.push_back(cyc);
         mosi_q.push_back(s_mosi);
      end
      if (!s_clk && prev_clk) sl_sh = sl_sh << 1;
      if (rx_valid) begin
         rx_t.push_back(cyc);
         rx_q.push_back(rx_data);
      end
      if (s_css && !prev_css) css_t.push_back(cyc);
      if (!busy && prev_busy) idle_t = cyc;
      prev_clk  = s_clk;
      prev_css  = s_css;
      prev_busy = busy;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int div;
      int data;
      bit loop;
      int slave;
      int exp_mosi;
      int exp_rx;
      int rise1;
      int rx_at;
      int css_at;
      int idle_at;
   } vec_t;

   vec_t vt[4];

   task automatic chk(input string nm, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  nm, got, got, exp, exp);
      end
   endtask

   task automatic arm(input int s16, input bit lp);
      rise_t.delete();
      mosi_q.delete();
      rx_t.delete();
      rx_q.delete();
      css_t.delete();
      acc_t.delete();
      idle_t  = -1;
      sl_sh   = s16[15:0];
      loop_en = lp;
   endtask

   task automatic send(input int d, input bit l, input int dv);
      bit got;
      got      = 1'b0;
      tx_data  = d[7:0];
      tx_last  = l;
      clk_div  = dv[DIV_W-1:0];
      tx_valid = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge p_clk);
         if (tx_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge p_clk);
      #2;
      tx_valid = 1'b0;
      if (!got) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int lim);
      bit done;
      done = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(posedge p_clk);
         if (idle_t >= 0) begin
            done = 1'b1;
            break;
         end
      end
      #2;
      if (!done) chk("idle_timeout", 0, 1);
   endtask

   function automatic int mbyte(input int b);
      logic [7:0] r;
      r = '0;
      if (mosi_q.size() < b + 8) return -1;
      for (int i = 0; i < 8; i++) r = {r[6:0], mosi_q[b+i]};
      return int'(r);
   endfunction

   function automatic int gaps(input int b, input int exp);
      int bad;
      bad = 0;
      if (rise_t.size() < b + 8) return 99;
      for (int i = 1; i < 8; i++) begin
         if (rise_t[b+i] - rise_t[b+i-1] != exp) bad++;
      end
      return bad;
   endfunction

   int a;
   int bad;

   initial begin
      // div, data, loop, slave, mosi, rx, rise1, rx_at, css_at, idle_at
      vt[0] = '{0,   'hA5, 1'b1, 'h00, 'hA5, 'hA5, 2,   17,   19,   20};
      vt[1] = '{1,   'h3C, 1'b0, 'h5A, 'h3C, 'h5A, 3,   33,   37,   39};
      vt[2] = '{2,   'hFF, 1'b0, 'h00, 'hFF, 'h00, 4,   49,   55,   58};
      vt[3] = '{255, 'h80, 1'b0, 'h01, 'h80, 'h01, 257, 4097, 4609, 4865};

      arm(0, 1'b1);
      repeat (3) @(posedge p_clk);
      #2;
      chk("rst_css", int'(s_css), 1);
      chk("rst_sclk", int'(s_clk), 0);
      chk("rst_mosi", int'(s_mosi), 0);
      chk("rst_ready", int'(tx_ready), 0);
      chk("rst_rxv", int'(rx_valid), 0);
      chk("rst_rxd", int'(rx_data), 0);
      chk("rst_busy", int'(busy), 0);
      p_reset_n = 1'b1;
      @(negedge p_clk);
      @(negedge p_clk);
      chk("rdy_after_rst", int'(tx_ready), 1);
      @(posedge p_clk);
      #2;

      for (int v = 0; v < 4; v++) begin
         arm(vt[v].slave << 8, vt[v].loop);
         send(vt[v].data, 1'b1, vt[v].div);
         wait_idle(6000);
         a = (acc_t.size() > 0) ? acc_t[0] : -100000;
         chk($sformatf("v%0d_rises", v), rise_t.size(), 8);
         chk($sformatf("v%0d_rise1", v),
             (rise_t.size() > 0) ? rise_t[0] - a : -1, vt[v].rise1);
         chk($sformatf("v%0d_mosi", v), mbyte(0), vt[v].exp_mosi);
         chk($sformatf("v%0d_rxcnt", v), rx_t.size(), 1);
         chk($sformatf("v%0d_rxd", v),
             (rx_q.size() > 0) ? int'(rx_q[0]) : -1, vt[v].exp_rx);
         chk($sformatf("v%0d_rx_at", v),
             (rx_t.size() > 0) ? rx_t[0] - a : -1, vt[v].rx_at);
         chk($sformatf("v%0d_css_at", v),
             (css_t.size() > 0) ? css_t[0] - a : -1, vt[v].css_at);
         chk($sformatf("v%0d_idle_at", v), idle_t - a, vt[v].idle_at);
      end

      // two bytes under one chip select, H=4
      arm(16'hFFEF, 1'b0);
      send('h9F, 1'b0, 3);
      send('h00, 1'b1, 3);
      wait_idle(2000);
      chk("mb_rises", rise_t.size(), 16);
      chk("mb_gap0", gaps(0, 8), 0);
      chk("mb_gap1", gaps(8, 8), 0);
      chk("mb_mosi0", mbyte(0), 'h9F);
      chk("mb_mosi1", mbyte(8), 'h00);
      chk("mb_rxcnt", rx_t.size(), 2);
      chk("mb_rx0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'hFF);
      chk("mb_rx1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, 'hEF);
      chk("mb_css_rise", css_t.size(), 1);
      chk("mb_css_at", (css_t.size() > 0 && rx_t.size() > 1)
          ? css_t[0] - rx_t[1] : -1, 8);

      // parked in WAIT for 50 cycles
      arm(0, 1'b0);
      send('h03, 1'b0, 0);
      for (int i = 0; i < 200; i++) begin
         @(negedge p_clk);
         if (tx_ready) break;
      end
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge p_clk);
         if (s_css || s_clk || !tx_ready || !busy) bad++;
      end
      chk("wait_hold", bad, 0);
      #1;
      chk("wait_rises", rise_t.size(), 8);
      chk("wait_css", css_t.size(), 0);
      @(posedge p_clk);
      #2;
      send('h00, 1'b1, 0);
      wait_idle(200);
      chk("wait_rxcnt", rx_t.size(), 2);

      // reset in the middle of a byte
      arm(0, 1'b1);
      send('hC3, 1'b1, 1);
      for (int i = 0; i < 200; i++) begin
         @(negedge p_clk);
         #1;
         if (rise_t.size() >= 4) break;
      end
      p_reset_n = 1'b0;
      #1;
      chk("mr_css", int'(s_css), 1);
      chk("mr_sclk", int'(s_clk), 0);
      chk("mr_busy", int'(busy), 0);
      repeat (2) @(posedge p_clk);
      #2;
      p_reset_n = 1'b1;
      @(negedge p_clk);
      chk("mr_rdy0", int'(tx_ready), 0);
      @(negedge p_clk);
      chk("mr_rdy1", int'(tx_ready), 1);
      chk("mr_rxcnt", rx_t.size(), 0);
      @(posedge p_clk);
      #2;

      // divider change and tx_valid held through SHIFT
      arm(0, 1'b1);
      tx_data  = 8'h55;
      tx_last  = 1'b0;
      clk_div  = 8'd1;
      tx_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge p_clk);
         if (tx_ready) break;
      end
      @(posedge p_clk);
      #2;
      clk_div = 8'd7;
      tx_data = 8'hAA;
      tx_last = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge p_clk);
         #1;
         if (acc_t.size() >= 2) break;
      end
      @(posedge p_clk);
      #2;
      tx_valid = 1'b0;
      wait_idle(1000);
      chk("dc_acc", acc_t.size(), 2);
      chk("dc_acc_at", (acc_t.size() > 1) ? acc_t[1] - acc_t[0] : -1, 35);
      chk("dc_gap0", gaps(0, 4), 0);
      chk("dc_gap1", gaps(8, 16), 0);
      chk("dc_rx0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'h55);
      chk("dc_rx1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, 'hAA);

`ifdef SPI_LSB_FIRST_EN
      arm(16'h8000, 1'b0);
      lsb_first = 1'b1;
      send('h01, 1'b1, 0);
      lsb_first = 1'b0;
      wait_idle(200);
      chk("lsb_bit0", (mosi_q.size() > 0) ? int'(mosi_q[0]) : -1, 1);
      chk("lsb_mosi", mbyte(0), 'h80);
      chk("lsb_rx", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 'h01);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
